move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter STEP_PERIOD, default 4, giving the minimum clock cycles between step pulses (legal range 2..2^26-1).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  scheduler enable; low blocks new steps.
REQ-005 SHALL have port req  input  4  held direction requests: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-006 SHALL have port busy  input  1  movement engine busy; high delays the next step.
REQ-007 SHALL have port grant  output  4  one-hot granted direction, registered, 0 when idle.
REQ-008 SHALL have port step  output  1  single-cycle move command, registered, qualifies grant.
REQ-009 SHALL have port active  output  1  high while the FSM is in RUN.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and RUN.
REQ-011 SHALL hold a 26-bit cycle counter and a 2-bit round-robin pointer ptr (index of the last granted bit).
REQ-012 SHALL, in IDLE with en=1 and req!=0, choose a winner by round-robin: first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-013 SHALL, on that same edge, register grant=one-hot(winner), step=1, ptr=winner, counter=0, state=RUN.
REQ-014 SHALL, in IDLE with en=0 or req=0, keep grant=0, step=0, and stay in IDLE.
REQ-015 SHALL drive step high for exactly one cycle per issued move, never two consecutive cycles.
REQ-016 SHALL, in RUN, increment counter each cycle, saturating at STEP_PERIOD-1.
REQ-017 SHALL define the decision point as RUN with counter==STEP_PERIOD-1 and busy=0; while busy=1 there, hold grant, step=0, and stay in RUN.
REQ-018 SHALL, at a decision point with en=1 and req[ptr]=1, keep grant unchanged, pulse step, and clear counter (sticky grant).
REQ-019 SHALL, at a decision point with en=1, req[ptr]=0 and req!=0, re-arbitrate per REQ-012, update grant and ptr, pulse step, and clear counter.
REQ-020 SHALL, at a decision point with en=0 or req=0, return to IDLE with grant=0 and step=0; ptr retained.
REQ-021 SHALL ignore req changes between decision points; grant stays stable for the whole RUN interval.
REQ-022 SHALL, with busy=0 and a request continuously present, space step pulses exactly STEP_PERIOD cycles apart.
REQ-023 SHALL, with busy high at the decision point, issue the step on the first edge after busy falls.
REQ-024 SHALL keep grant one-hot or zero at all times, and active=1 exactly when state=RUN.
REQ-025 SHALL treat req as already synchronous and held (pulse-stretched upstream); no internal synchronizer.

Reset
REQ-026 SHALL, on rst=1, immediately force state=IDLE, grant=0, step=0, active=0, counter=0, ptr=3 (first search starts at up).
REQ-027 SHALL abort any RUN interval on reset mid-operation, with no step pulse during or on the first edge after rst deasserts unless REQ-012 conditions hold.

Verification (STEP_PERIOD=4)
REQ-028 SHALL verify: after reset, req=0001, en=1, busy=0 held -> step pulses at edges 0,4,8,...; grant=0001 throughout; active=1.
REQ-029 SHALL verify round-robin: req=1111 from IDLE with ptr=3 -> grant 0001; each time the winning bit drops before a decision point -> grant 0010, then 0100, then 1000, then 0001.
REQ-030 SHALL verify the busy stall: busy=1 from edge 2 to edge 9 -> no step until the edge after busy falls (edge 10); counter held at 3 meanwhile.
REQ-031 SHALL verify release: req drops to 0 at edge 2 -> at edge 4 grant=0, active=0, no step; a new req=0100 at edge 6 -> step with grant=0100 at edge 7.
REQ-032 SHALL verify en=0 asserted mid-RUN -> no further step; IDLE at the next decision point; grant=0.
REQ-033 SHALL verify rst pulsed at edge 2 of RUN -> outputs 0 immediately and ptr=3; after release with req=0010 -> grant=0010 and step on the first edge.

Source files
------------

// File: rtl/move_scheduler.sv
// Round-robin move scheduler: arbitrates four held direction requests and
// issues single-cycle step commands no closer than STEP_PERIOD cycles apart.
module move_scheduler #(
  parameter int unsigned STEP_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       busy,
  output logic [3:0] grant,
  output logic       step,
  output logic       active
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [25:0] LAST = 26'(STEP_PERIOD - 1);

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic        step_q, step_d;
  logic [1:0]  win;

  // Scan offsets from farthest to nearest so the nearest set bit after ptr wins;
  // offset 4 wraps to ptr itself, which therefore has the lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    step_d  = 1'b0;
    win     = rr_pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (en && (req != 4'b0000)) begin
          grant_d = 4'b0001 << win;
          ptr_d   = win;
          cnt_d   = '0;
          step_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + 26'd1;
        end else if (!busy) begin
          if (en && req[ptr_q]) begin
            step_d = 1'b1;
            cnt_d  = '0;
          end else if (en && (req != 4'b0000)) begin
            grant_d = 4'b0001 << win;
            ptr_d   = win;
            step_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      grant_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      step_q  <= step_d;
    end
  end

  assign grant  = grant_q;
  assign step   = step_q;
  assign active = (state_q == RUN);

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios with constant expectations plus
// a randomized run against an event-level reference model.
module tb_move_scheduler;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       busy = 1'b0;
  logic [3:0] grant;
  logic       step;
  logic       active;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: elapsed cycles since the last step, granted index.
  bit m_run;
  int m_el;
  int m_ptr;
  int m_g;
  bit m_step;

  move_scheduler #(.STEP_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .busy(busy),
    .grant(grant), .step(step), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000; busy = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int g);
    logic [3:0] v;
    v = 4'b0000;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_el = 0; m_ptr = 3; m_g = -1; m_step = 0;
    end else if (!m_run) begin
      m_step = 0; m_g = -1;
      if (en && req != 4'b0000) begin
        m_g = rr(req, m_ptr); m_ptr = m_g; m_step = 1; m_run = 1; m_el = 0;
      end
    end else begin
      m_step = 0;
      if (m_el >= P - 1 && !busy) begin
        if (en && req != 4'b0000) begin
          if (!req[m_ptr]) begin
            m_g = rr(req, m_ptr); m_ptr = m_g;
          end
          m_step = 1; m_el = 0;
        end else begin
          m_run = 0; m_g = -1; m_el = 0;
        end
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; req = 4'b0001; busy = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, step, active} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_async: grant=%b step=%b active=%b expected 0000 0 0", grant, step, active);
    end
    cyc();
    n_cmp++;
    if ({grant, step, active} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_held: grant=%b step=%b active=%b expected 0000 0 0", grant, step, active);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    en = 1'b1; req = 4'b0001; busy = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      cyc();
      n_cmp++;
      if (step !== (e % 4 == 0) || grant !== 4'b0001 || active !== 1'b1) begin
        n_err++;
        $display("FAIL sticky e%0d: grant=%b step=%b active=%b expected 0001 %0d 1",
                 e, grant, step, active, (e % 4 == 0));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    en = 1'b1; req = 4'b1111; busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int e = 0; e < 4; e++) begin
        cyc();
        n_cmp++;
        if (step !== (e == 0) || grant !== seq[i] || active !== 1'b1) begin
          n_err++;
          $display("FAIL round_robin i%0d e%0d: grant=%b step=%b expected %b %0d",
                   i, e, grant, step, seq[i], (e == 0));
        end
        if (e == 0) req = 4'b1111 & ~seq[i];
      end
    end
  endtask

  task automatic test_busy_stall();
    do_reset();
    en = 1'b1; req = 4'b0001; busy = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      cyc();
      n_cmp++;
      if (step !== (e == 0 || e == 10 || e == 14) || grant !== 4'b0001 || active !== 1'b1) begin
        n_err++;
        $display("FAIL busy_stall e%0d: grant=%b step=%b active=%b expected 0001 %0d 1",
                 e, grant, step, active, (e == 0 || e == 10 || e == 14));
      end
      if (e == 1) busy = 1'b1;
      if (e == 9) busy = 1'b0;
    end
  endtask

  task automatic test_release();
    logic [3:0] eg;
    logic es, ea;
    do_reset();
    en = 1'b1; req = 4'b0001; busy = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      cyc();
      if (e <= 3) begin
        eg = 4'b0001; es = (e == 0); ea = 1'b1;
      end else if (e <= 6) begin
        eg = 4'b0000; es = 1'b0; ea = 1'b0;
      end else begin
        eg = 4'b0100; es = (e == 7); ea = 1'b1;
      end
      n_cmp++;
      if (grant !== eg || step !== es || active !== ea) begin
        n_err++;
        $display("FAIL release e%0d: grant=%b step=%b active=%b expected %b %b %b",
                 e, grant, step, active, eg, es, ea);
      end
      if (e == 1) req = 4'b0000;
      if (e == 6) req = 4'b0100;
    end
  endtask

  task automatic test_enable_off();
    logic [3:0] eg;
    logic es, ea;
    do_reset();
    en = 1'b1; req = 4'b0010; busy = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      cyc();
      eg = (e <= 3) ? 4'b0010 : 4'b0000;
      es = (e == 0);
      ea = (e <= 3);
      n_cmp++;
      if (grant !== eg || step !== es || active !== ea) begin
        n_err++;
        $display("FAIL enable_off e%0d: grant=%b step=%b active=%b expected %b %b %b",
                 e, grant, step, active, eg, es, ea);
      end
      if (e == 1) en = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rq, eg;
    for (int pass = 0; pass < 2; pass++) begin
      rq = (pass == 0) ? 4'b0011 : 4'b0010;
      eg = (pass == 0) ? 4'b0001 : 4'b0010;
      do_reset();
      en = 1'b1; req = 4'b0001; busy = 1'b0;
      cyc();
      cyc();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({grant, step, active} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_mid_async p%0d: grant=%b step=%b active=%b expected 0000 0 0",
                 pass, grant, step, active);
      end
      cyc();
      n_cmp++;
      if ({grant, step, active} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_mid_edge p%0d: grant=%b step=%b active=%b expected 0000 0 0",
                 pass, grant, step, active);
      end
      rst = 1'b0;
      req = rq;
      cyc();
      n_cmp++;
      if (grant !== eg || step !== 1'b1 || active !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_restart p%0d: grant=%b step=%b active=%b expected %b 1 1",
                 pass, grant, step, active, eg);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    m_run = 0; m_el = 0; m_ptr = 3; m_g = -1; m_step = 0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 9) != 0);
      busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) req = 4'b0000;
      model_edge();
      cyc();
      eg = oh(m_g);
      n_cmp++;
      if (grant !== eg || step !== m_step || active !== m_run) begin
        n_err++;
        $display("FAIL random c%0d: grant=%b step=%b active=%b expected %b %b %b",
                 c, grant, step, active, eg, m_step, m_run);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sticky();
    test_round_robin();
    test_busy_stall();
    test_release();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
